adder_rr_arbiter: RTL and testbench
===================================

Name: adder_rr_arbiter

Overview:
- Shares one sqrt carry-select adder between NUM_REQ requesters (Booth partial-product reducers, final-sum stage) using round-robin arbitration.
- Valid/ready handshake on each request port and on one response port.
- One grant per cycle; the result is registered with 1-cycle latency and a one-deep output buffer that absorbs backpressure.

Parameters:
- WIDTH, 16, operand/sum width passed to the adder.
- NUM_REQ, 4, number of requesters (≥2).
- ID_W, $clog2(NUM_REQ), width of requester index.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand B, same packing.
- req_cin  in  NUM_REQ  carry-in per requester.
- resp_valid  out  1  registered result valid.
- resp_ready  in  1  downstream accept.
- resp_sum  out  WIDTH  (a+b+cin) mod 2^WIDTH.
- resp_cout  out  1  carry out of bit WIDTH-1.
- resp_id  out  ID_W  index of requester that produced the result.

Behaviour:
- Reset (synchronous, active-high, applied at a clk edge):
  - resp_valid=0, resp_sum=0, resp_cout=0, resp_id=0.
  - Round-robin pointer=0, so requester 0 has highest priority.
  - A pending response is discarded. No grant in a reset cycle: req_ready=0 while rst=1.
- Slot free: slot_free = !resp_valid || resp_ready.
- Grant (combinational):
  - If slot_free, grant the first valid requester searching from pointer upward, wrapping modulo NUM_REQ.
  - req_ready = grant vector. At most one bit is set; it is zero when no request is valid or the slot is not free.
  - req_ready never depends on the granted requester's own data; it may depend on req_valid.
- Transfer: a transfer happens when req_valid[i] && req_ready[i].
- Adder path: mux the selected a/b/cin into the shared adder (combinational). At the edge, capture sum, cout and id into the response register, and set resp_valid=1.
- Latency: an operation accepted in cycle N appears on resp_* in cycle N+1.
- Throughput: 1 operation per cycle while resp_ready=1.
- Same-cycle drain and refill: if resp_valid && resp_ready and a new grant occurs in the same cycle, the register loads the new result and resp_valid stays 1.
- Drain only: if resp_valid && resp_ready with no grant, resp_valid goes to 0 next cycle.
- Backpressure: while resp_valid && !resp_ready, resp_sum/resp_cout/resp_id are held stable, all req_ready=0, and the pointer is unchanged.
- Pointer update: only on a transfer, pointer <= (granted index + 1) mod NUM_REQ; wrap from NUM_REQ-1 to 0.
- Fairness: a continuously asserted requester is granted within NUM_REQ transfers.
- Requester obligations: hold valid and data until accepted. The arbiter does not check this.
- State machine: implicit two-state EMPTY (resp_valid=0) and FULL (resp_valid=1).
  - EMPTY→FULL on a grant.
  - FULL→EMPTY on drain without a grant.
  - FULL→FULL on drain with a grant, or on a stall.
- Width rules:
  - Sum truncated to WIDTH, cout separate. No sign interpretation.
  - 0xFFFF+0xFFFF+1 at WIDTH=16 gives sum 0xFFFF, cout 1.

Decomposition:
- Shared package: ID_W computation helper and DEFAULT_WIDTH=16. No typedefs required; ports are flat vectors.
- Sub-module: instantiate the existing sqrt_carry_select_adder (WIDTH=WIDTH) once.
- The round-robin grant logic is a natural second sub-module, rr_grant (pointer, valid vector → one-hot grant). It is purely combinational; the pointer register stays in adder_rr_arbiter.

Test Plan:
- Single request (WIDTH=16, NUM_REQ=4): req_valid=0001, a=0x1234, b=0x4321, cin=0, resp_ready=1 → req_ready=0001 same cycle; next cycle resp_valid=1, sum=0x5555, cout=0, id=0.
- Carry out: requester 2, a=0xFFFF, b=0x0001, cin=1 → sum=0x0001, cout=1, id=2, one cycle after acceptance.
- Continuous contention: all four valid every cycle, resp_ready=1 → resp_id sequence 0,1,2,3,0,1 on consecutive cycles, resp_valid held at 1.
- Priority after grant: after a grant to 2, only requesters 1 and 3 valid → 3 granted first, then 1.
- Backpressure: resp_ready=0 for 3 cycles with req_valid=1111 → req_ready=0000, resp_* stable, pointer unchanged; resp_ready=1 → drain and next grant in the same cycle, resp_valid stays 1.
- Reset mid-operation: assert rst for one cycle while resp_valid=1 and resp_ready=0 → next cycle resp_valid=0 and outputs 0; first grant after reset goes to requester 0 when all are valid.

Source files
------------

// File: rtl/adder_rr_arbiter_pkg.sv
// Shared constants and elaboration helpers for the round-robin adder arbiter.
package adder_rr_arbiter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  // Requester index width; a single requester still needs one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Smallest r with r*r >= n, used to size carry-select blocks.
  function automatic int unsigned ceil_sqrt(input int unsigned n);
    int unsigned r;
    r = 1;
    while (r * r < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/adder_rr_arbiter_adder.sv
// Square-root carry-select adder: ripple inside blocks, carry selects precomputed block sums.
module sqrt_carry_select_adder
  import adder_rr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned BLK = ceil_sqrt(WIDTH);
  localparam int unsigned NB  = (WIDTH + BLK - 1) / BLK;

  logic [NB:0] carry;

  assign carry[0] = cin;
  assign cout     = carry[NB];

  for (genvar k = 0; k < NB; k++) begin : g_blk
    localparam int unsigned LO = k * BLK;
    localparam int unsigned BW = ((WIDTH - LO) < BLK) ? (WIDTH - LO) : BLK;

    logic [BW:0] r0;
    logic [BW:0] r1;

    // Both carry-in cases computed up front; the incoming carry only selects.
    assign r0 = (BW+1)'(a[LO +: BW]) + (BW+1)'(b[LO +: BW]);
    assign r1 = r0 + (BW+1)'(1);

    assign sum[LO +: BW] = carry[k] ? r1[BW-1:0] : r0[BW-1:0];
    assign carry[k+1]    = carry[k] ? r1[BW] : r0[BW];
  end

endmodule

// File: rtl/adder_rr_arbiter_rr_grant.sv
// Combinational round-robin picker: first valid requester at or above ptr, wrapping.
module rr_grant
  import adder_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic [ID_W-1:0]    ptr,
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    gnt_id
);

  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    grant  = '0;
    gnt_id = '0;
    idx    = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((32'(ptr) + i) % NUM_REQ);
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        gnt_id     = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one carry-select adder among NUM_REQ requesters,
// with a one-deep registered response slot.
module adder_rr_arbiter
  import adder_rr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         resp_sum,
  output logic                     resp_cout,
  output logic [ID_W-1:0]          resp_id
);

  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gnt_id;
  logic               slot_free;
  logic               xfer;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               op_cin;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_grant (
    .ptr    (ptr),
    .valid  (req_valid),
    .grant  (grant),
    .gnt_id (gnt_id)
  );

  assign slot_free = !resp_valid || resp_ready;
  assign req_ready = (slot_free && !rst) ? grant : '0;
  assign xfer      = |req_ready;

  // Operand mux driven by the granted index.
  always_comb begin
    op_a   = '0;
    op_b   = '0;
    op_cin = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == gnt_id) begin
        op_a   = req_a[i*WIDTH +: WIDTH];
        op_b   = req_b[i*WIDTH +: WIDTH];
        op_cin = req_cin[i];
      end
    end
  end

  sqrt_carry_select_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (op_a),
    .b    (op_b),
    .cin  (op_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Response slot (EMPTY/FULL via resp_valid) and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_sum   <= '0;
      resp_cout  <= 1'b0;
      resp_id    <= '0;
      ptr        <= '0;
    end else if (xfer) begin
      resp_valid <= 1'b1;
      resp_sum   <= add_sum;
      resp_cout  <= add_cout;
      resp_id    <= gnt_id;
      ptr        <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed self-checking bench for adder_rr_arbiter (WIDTH=16, NUM_REQ=4).
module tb_adder_rr_arbiter;

  localparam int unsigned W = 16;
  localparam int unsigned N = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_cin;
  logic           resp_valid;
  logic           resp_ready;
  logic [W-1:0]   resp_sum;
  logic           resp_cout;
  logic [1:0]     resp_id;

  logic [W-1:0] a_v [N];
  logic [W-1:0] b_v [N];
  logic         c_v [N];

  int checks;
  int failures;

  adder_rr_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_sum   (resp_sum),
    .resp_cout  (resp_cout),
    .resp_id    (resp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = a_v[i];
      req_b[i*W +: W] = b_v[i];
      req_cin[i]      = c_v[i];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Contention data: sums 0x1001, 0x2002, 0x3003, 0x4004, no carry.
  task automatic load_std_data();
    for (int i = 0; i < N; i++) begin
      a_v[i] = W'((i + 1) * 16'h1000);
      b_v[i] = W'(i + 1);
      c_v[i] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; resp_ready = 1'b1; req_valid = 4'b1111;
    step();
    step();
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_sum !== 16'h0 || resp_cout !== 1'b0 || resp_id !== 2'd0) begin
      failures++; $display("FAIL reset_outputs got sum=%h cout=%b id=%0d exp 0/0/0", resp_sum, resp_cout, resp_id); end
    req_valid = 4'b0000;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    a_v[0] = 16'h1234; b_v[0] = 16'h4321; c_v[0] = 1'b0;
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
    step();
    req_valid = 4'b0000;
    checks++; if (resp_valid !== 1'b1 || resp_sum !== 16'h5555 || resp_cout !== 1'b0 || resp_id !== 2'd0) begin
      failures++; $display("FAIL single_resp got v=%b sum=%h cout=%b id=%0d exp 1/5555/0/0", resp_valid, resp_sum, resp_cout, resp_id); end
    step();
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL drain_only got=%b exp=0", resp_valid); end
  endtask

  task automatic test_carry();
    // Pointer is 1; requester 2 is the only one valid.
    a_v[2] = 16'hFFFF; b_v[2] = 16'h0001; c_v[2] = 1'b1;
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL carry_ready got=%b exp=0100", req_ready); end
    step();
    req_valid = 4'b0000;
    checks++; if (resp_valid !== 1'b1 || resp_sum !== 16'h0001 || resp_cout !== 1'b1 || resp_id !== 2'd2) begin
      failures++; $display("FAIL carry_resp got v=%b sum=%h cout=%b id=%0d exp 1/0001/1/2", resp_valid, resp_sum, resp_cout, resp_id); end
    // Max operands through requester 3.
    a_v[3] = 16'hFFFF; b_v[3] = 16'hFFFF; c_v[3] = 1'b1;
    req_valid = 4'b1000;
    step();
    req_valid = 4'b0000;
    checks++; if (resp_sum !== 16'hFFFF || resp_cout !== 1'b1 || resp_id !== 2'd3) begin
      failures++; $display("FAIL max_resp got sum=%h cout=%b id=%0d exp FFFF/1/3", resp_sum, resp_cout, resp_id); end
    step();
  endtask

  task automatic test_contention();
    logic [W-1:0] exp_sum [N];
    exp_sum[0] = 16'h1001; exp_sum[1] = 16'h2002; exp_sum[2] = 16'h3003; exp_sum[3] = 16'h4004;
    load_std_data();
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (req_ready !== 4'(1 << (k % 4))) begin
        failures++; $display("FAIL cont_ready[%0d] got=%b exp=%b", k, req_ready, 4'(1 << (k % 4))); end
      step();
      checks++; if (resp_valid !== 1'b1 || resp_id !== 2'(k % 4) || resp_sum !== exp_sum[k % 4]) begin
        failures++; $display("FAIL cont_resp[%0d] got v=%b id=%0d sum=%h exp 1/%0d/%h", k, resp_valid, resp_id, resp_sum, k % 4, exp_sum[k % 4]); end
    end
    req_valid = 4'b0000;
    step();
  endtask

  task automatic test_priority();
    // Pointer is 2: grant 2, then with only 1 and 3 valid, 3 wins before 1.
    req_valid = 4'b0100;
    step();
    req_valid = 4'b1010;
    #1;
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL prio_first got=%b exp=1000", req_ready); end
    step();
    checks++; if (resp_id !== 2'd3 || resp_sum !== 16'h4004) begin
      failures++; $display("FAIL prio_resp3 got id=%0d sum=%h exp 3/4004", resp_id, resp_sum); end
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL prio_second got=%b exp=0010", req_ready); end
    step();
    checks++; if (resp_id !== 2'd1 || resp_sum !== 16'h2002) begin
      failures++; $display("FAIL prio_resp1 got id=%0d sum=%h exp 1/2002", resp_id, resp_sum); end
    req_valid = 4'b0000;
    step();
  endtask

  task automatic test_backpressure();
    // Pointer is 2; fill the slot with requester 2.
    req_valid = 4'b1111;
    step();
    resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0000", k, req_ready); end
      step();
      checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_sum !== 16'h3003 || resp_cout !== 1'b0) begin
        failures++; $display("FAIL bp_hold[%0d] got v=%b id=%0d sum=%h exp 1/2/3003", k, resp_valid, resp_id, resp_sum); end
    end
    resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL bp_release_ready got=%b exp=1000", req_ready); end
    step();
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd3 || resp_sum !== 16'h4004) begin
      failures++; $display("FAIL bp_refill got v=%b id=%0d sum=%h exp 1/3/4004", resp_valid, resp_id, resp_sum); end
  endtask

  task automatic test_reset_mid();
    // Grant requester 0 so the pointer sits at 1 before the reset.
    step();
    checks++; if (resp_id !== 2'd0) begin failures++; $display("FAIL pre_reset_id got=%0d exp=0", resp_id); end
    resp_ready = 1'b0;
    step();
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rst_mid_ready got=%b exp=0000", req_ready); end
    step();
    rst = 1'b0;
    checks++; if (resp_valid !== 1'b0 || resp_sum !== 16'h0 || resp_cout !== 1'b0 || resp_id !== 2'd0) begin
      failures++; $display("FAIL rst_mid_out got v=%b sum=%h cout=%b id=%0d exp 0/0/0/0", resp_valid, resp_sum, resp_cout, resp_id); end
    resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rst_mid_grant got=%b exp=0001", req_ready); end
    step();
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_sum !== 16'h1001) begin
      failures++; $display("FAIL rst_mid_resp got v=%b id=%0d sum=%h exp 1/0/1001", resp_valid, resp_id, resp_sum); end
    req_valid = 4'b0000;
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    resp_ready = 1'b1;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      a_v[i] = '0; b_v[i] = '0; c_v[i] = 1'b0;
    end
    test_reset();
    test_single();
    test_carry();
    test_contention();
    test_priority();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
